uart_frame_depacketizer: RTL and testbench

// - Consumes bytes from UART_Rx over its valid/ack handshake and rebuilds multi-byte sample words.
// - Frame format: sync byte, then C_WORD_BYTES payload bytes (LSB first), then one XOR checksum byte.
// - Host-command/readback side of the SDAD UART link; the counterpart of the word-to-byte packetizer on the Tx side.
// - Delivers checked words on a valid/ready stream and reports framing errors.

---
 rtl/sdad_uart_pkg.sv | 27 ++
 rtl/uart_frame_depacketizer_if.sv | 31 +++
 rtl/uart_rx_handshake.sv | 32 +++
 rtl/uart_frame_depacketizer.sv | 159 +++++++++++++++
 tb/tb_uart_frame_depacketizer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sdad_uart_pkg.sv
// Shared types for the SDAD UART link.
// FSM states, error causes and a saturating counter helper.
package sdad_uart_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    OUT     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_CHK  = 2'b01,
    ERR_TMO  = 2'b10,
    ERR_RX   = 2'b11
  } err_t;

  localparam logic [7:0] C_SYNC_DEFAULT = 8'hA5;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_frame_depacketizer_if.sv
// Byte-in / word-out bundle of the frame depacketizer.
// slave = depacketizer side, master = UART_Rx + consumer side.
interface uart_frame_depacketizer_if #(
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_WORD_BYTES      = 2
);
  localparam int W = C_UART_DATA_WIDTH * C_WORD_BYTES;

  logic [C_UART_DATA_WIDTH-1:0] rxData;
  logic                         rxValid;
  logic                         rxErr;
  logic                         rxAck;
  logic [W-1:0]                 word;
  logic                         wordValid;
  logic                         wordReady;
  logic                         frameErr;
  logic [1:0]                   errCode;
  logic [7:0]                   errCount;

  modport slave (
    input  rxData, rxValid, rxErr, wordReady,
    output rxAck, word, wordValid,
    output frameErr, errCode, errCount
  );

  modport master (
    output rxData, rxValid, rxErr, wordReady,
    input  rxAck, word, wordValid,
    input  frameErr, errCode, errCount
  );
endinterface

// File: rtl/uart_rx_handshake.sv
// Four-phase acknowledge generator toward UART_Rx.
// byte_stb marks the single cycle a byte is taken.
module uart_rx_handshake (
  input  logic clk,
  input  logic rst,
  input  logic rx_valid,
  input  logic accept_en,
  output logic rx_ack,
  output logic byte_stb
);

  logic ack_q, ack_d;

  assign byte_stb = rx_valid & ~ack_q & accept_en;
  assign rx_ack   = ack_q;

  // raise ack on accept, drop it once valid is seen low
  always_comb begin
    ack_d = ack_q;
    if (byte_stb)
      ack_d = 1'b1;
    else if (ack_q && !rx_valid)
      ack_d = 1'b0;
  end

  // ack register
  always_ff @(posedge clk) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= ack_d;
  end

endmodule

// File: rtl/uart_frame_depacketizer.sv
// Rebuilds sync/payload/XOR-checksum frames into words.
// Errors pulse frameErr and are latched in errCode/errCount.
module uart_frame_depacketizer
  import sdad_uart_pkg::*;
#(
  parameter int         C_UART_DATA_WIDTH = 8,
  parameter int         C_WORD_BYTES      = 2,
  parameter logic [7:0] C_SYNC            = C_SYNC_DEFAULT,
  parameter int         C_TIMEOUT_CLK     = 100_000
) (
  input logic                      clk,
  input logic                      rst,
  uart_frame_depacketizer_if.slave bus
);

  localparam int DW = C_UART_DATA_WIDTH;
  localparam int W  = DW * C_WORD_BYTES;
  localparam int TW = $clog2(C_TIMEOUT_CLK);
  localparam logic [TW-1:0] TMO_MAX =
    TW'(C_TIMEOUT_CLK - 1);
  localparam logic [1:0] LAST =
    2'(C_WORD_BYTES - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [W-1:0]   word_q, word_d;
  logic [1:0]     idx_q, idx_d;
  logic [DW-1:0]  chk_q, chk_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           wv_q, wv_d;
  logic           fe_q, fe_d;
  err_t           ec_q, ec_d;
  logic [7:0]     cnt_q, cnt_d;
  err_t           err_sel;
  logic           byte_stb;
  logic           accept_en;
  logic           in_frame;

  // bytes are refused while a word waits downstream
  assign accept_en = (state_q != OUT);
  assign in_frame  = (state_q == PAYLOAD) ||
                     (state_q == CHECK);

  uart_rx_handshake u_hs (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (bus.rxValid),
    .accept_en (accept_en),
    .rx_ack    (bus.rxAck),
    .byte_stb  (byte_stb)
  );

  // frame FSM, shift register, checksum and timeout
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    word_d  = word_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    wv_d    = wv_q;
    fe_d    = 1'b0;
    ec_d    = ec_q;
    cnt_d   = cnt_q;
    err_sel = ERR_NONE;
    tmo_d   = (in_frame && !byte_stb) ?
              tmo_q + TW'(1) : '0;

    unique case (state_q)
      HUNT: begin
        if (byte_stb && !bus.rxErr &&
            bus.rxData == C_SYNC) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      PAYLOAD: begin
        if (byte_stb) begin
          if (bus.rxErr) begin
            err_sel = ERR_RX;
          end else begin
            sh_d  = (sh_q >> DW) |
                    (W'(bus.rxData) << (W - DW));
            chk_d = chk_q ^ bus.rxData;
            idx_d = idx_q + 2'd1;
            if (idx_q == LAST)
              state_d = CHECK;
          end
        end else if (tmo_q == TMO_MAX) begin
          err_sel = ERR_TMO;
        end
      end
      CHECK: begin
        if (byte_stb) begin
          if (bus.rxErr) begin
            err_sel = ERR_RX;
          end else if (bus.rxData == chk_q) begin
            state_d = OUT;
            wv_d    = 1'b1;
            word_d  = sh_q;
          end else begin
            err_sel = ERR_CHK;
          end
        end else if (tmo_q == TMO_MAX) begin
          err_sel = ERR_TMO;
        end
      end
      OUT: begin
        if (wv_q && bus.wordReady) begin
          state_d = HUNT;
          wv_d    = 1'b0;
        end
      end
      default: state_d = HUNT;
    endcase

    if (err_sel != ERR_NONE) begin
      state_d = HUNT;
      tmo_d   = '0;
      fe_d    = 1'b1;
      ec_d    = err_sel;
      cnt_d   = sat_inc8(cnt_q);
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sh_q    <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
      tmo_q   <= '0;
      wv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ec_q    <= ERR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      tmo_q   <= tmo_d;
      wv_q    <= wv_d;
      fe_q    <= fe_d;
      ec_q    <= ec_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.word      = word_q;
  assign bus.wordValid = wv_q;
  assign bus.frameErr  = fe_q;
  assign bus.errCode   = ec_q;
  assign bus.errCount  = cnt_q;

endmodule

// File: tb/tb_uart_frame_depacketizer.sv
// Directed bench for uart_frame_depacketizer.
// Short timeout parameter keeps idle tests brief.
module tb_uart_frame_depacketizer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_frame_depacketizer_if #(
    .C_UART_DATA_WIDTH (8),
    .C_WORD_BYTES      (2)
  ) ifc ();

  uart_frame_depacketizer #(
    .C_UART_DATA_WIDTH (8),
    .C_WORD_BYTES      (2),
    .C_SYNC            (8'hA5),
    .C_TIMEOUT_CLK     (50)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_chk = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int word_cnt = 0;
  logic [15:0] last_word = '0;
  logic ack_wv;
  logic ack_seen;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h",
               tag, got, exp);
    end
  endtask

  // observe error pulses and accepted words
  always @(negedge clk) begin
    if (ifc.frameErr === 1'b1)
      fe_cnt++;
    if (ifc.wordValid && ifc.wordReady) begin
      word_cnt++;
      last_word = ifc.word;
    end
  end

  task automatic wait_ack(input logic v);
    int n;
    n = 0;
    while (ifc.rxAck !== v && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ifc.rxAck !== v)
      check("ack_wait", 32'(ifc.rxAck), 32'(v));
  endtask

  task automatic send_byte(
    input logic [7:0] b,
    input logic       e
  );
    wait_ack(1'b0);
    ifc.rxData  = b;
    ifc.rxValid = 1'b1;
    ifc.rxErr   = e;
    @(negedge clk);
    wait_ack(1'b1);
    ack_wv      = ifc.wordValid;
    ifc.rxValid = 1'b0;
    ifc.rxErr   = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    ifc.rxData    = '0;
    ifc.rxValid   = 1'b0;
    ifc.rxErr     = 1'b0;
    ifc.wordReady = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack",   32'(ifc.rxAck),     0);
    check("rst_wv",    32'(ifc.wordValid), 0);
    check("rst_fe",    32'(ifc.frameErr),  0);
    check("rst_code",  32'(ifc.errCode),   0);
    check("rst_cnt",   32'(ifc.errCount),  0);
    check("rst_word",  32'(ifc.word),      0);
    rst = 1'b0;
    @(negedge clk);

    // good frame
    send_byte(8'hA5, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'h26, 0);
    check("f1_wv_lat", 32'(ack_wv), 1);
    settle();
    check("f1_word", 32'(last_word), 32'h1234);
    check("f1_nword", word_cnt, 1);
    check("f1_fe", fe_cnt, 0);

    // bad checksum
    send_byte(8'hA5, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'h00, 0);
    settle();
    check("chk_fe", fe_cnt, 1);
    check("chk_code", 32'(ifc.errCode), 1);
    check("chk_cnt", 32'(ifc.errCount), 1);
    check("chk_nword", word_cnt, 1);

    // timeout mid-frame, then recovery
    send_byte(8'hA5, 0);
    send_byte(8'h34, 0);
    repeat (60) @(negedge clk);
    check("tmo_fe", fe_cnt, 2);
    check("tmo_code", 32'(ifc.errCode), 2);
    check("tmo_cnt", 32'(ifc.errCount), 2);
    send_byte(8'hA5, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h2E, 0);
    settle();
    check("tmo_word", 32'(last_word), 32'h5678);
    check("tmo_nword", word_cnt, 2);

    // junk dropped, sync as payload data
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hA5, 0);
    send_byte(8'hA5, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    settle();
    check("junk_word", 32'(last_word), 32'hA5A5);
    check("junk_nword", word_cnt, 3);
    check("junk_fe", fe_cnt, 2);

    // backpressure then rxErr frame
    ifc.wordReady = 1'b0;
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    ifc.rxData  = 8'hA5;
    ifc.rxValid = 1'b1;
    ack_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ifc.rxAck) ack_seen = 1'b1;
    end
    check("bp_ack", 32'(ack_seen), 0);
    check("bp_wv", 32'(ifc.wordValid), 1);
    check("bp_word", 32'(ifc.word), 32'h2211);
    check("bp_nword", word_cnt, 3);
    ifc.wordReady = 1'b1;
    @(negedge clk);
    wait_ack(1'b1);
    ifc.rxValid = 1'b0;
    wait_ack(1'b0);
    send_byte(8'h44, 1);
    settle();
    check("bp_word2", 32'(last_word), 32'h2211);
    check("bp_nword2", word_cnt, 4);
    check("rx_fe", fe_cnt, 3);
    check("rx_code", 32'(ifc.errCode), 3);
    check("rx_cnt", 32'(ifc.errCount), 3);

    // rxErr while hunting only drops the byte
    send_byte(8'hA5, 1);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'h26, 0);
    settle();
    check("hunt_rx_fe", fe_cnt, 3);
    check("hunt_rx_nw", word_cnt, 4);

    // error counter saturation
    repeat (260) begin
      send_byte(8'hA5, 0);
      send_byte(8'h00, 1);
    end
    settle();
    check("sat_cnt", 32'(ifc.errCount), 32'hFF);

    // reset mid-frame while ack is high
    send_byte(8'hA5, 0);
    ifc.rxData  = 8'h34;
    ifc.rxValid = 1'b1;
    @(negedge clk);
    wait_ack(1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_ack", 32'(ifc.rxAck), 0);
    check("mrst_wv", 32'(ifc.wordValid), 0);
    check("mrst_cnt", 32'(ifc.errCount), 0);
    check("mrst_code", 32'(ifc.errCode), 0);
    ifc.rxValid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'hA5, 0);
    send_byte(8'hBC, 0);
    send_byte(8'h9A, 0);
    send_byte(8'h26, 0);
    settle();
    check("mrst_word", 32'(last_word), 32'h9ABC);
    check("mrst_nword", word_cnt, 5);
    check("mrst_ecnt", 32'(ifc.errCount), 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
